sp_eval: RTL and testbench

Sprite evaluation and pattern-fetch engine for the PPU. Once per scanline it scans the 64-entry primary OAM for sprites that intersect the next scanline, keeps the first eight, and fetches their pattern bytes from VRAM. It then presents them as the `second_oam_t [7:0]` array that the per-pixel sprite renderer consumes during the following line. It is the producer side of the secondary-OAM interface.

---
 rtl/sp_eval_pkg.sv | 31 +++
 rtl/sp_eval_pat_addr.sv | 31 +++
 rtl/sp_eval.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_sp_eval.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_eval_pkg.sv
// Shared types and constants for the sprite evaluation engine.
//   second_oam_t    : one committed secondary-OAM slot as seen by the renderer
//   SPRITE_HEIGHT_* : sprite heights for 8x8 / 8x16 mode
//   OAM_ENTRIES     : number of 4-byte entries in primary OAM
//   sp_eval_state_t : evaluation FSM state encoding
package sp_eval_pkg;

  typedef struct packed {
    logic       active;
    logic [7:0] x_pos;
    logic [7:0] attribute;
    logic [7:0] bitmap_lo;
    logic [7:0] bitmap_hi;
  } second_oam_t;

  localparam logic [4:0] SPRITE_HEIGHT_8  = 5'd8;
  localparam logic [4:0] SPRITE_HEIGHT_16 = 5'd16;
  localparam int         OAM_ENTRIES      = 64;

  // state | meaning
  // IDLE  | waiting for start; wbuf holds the last completed (or aborted) line
  // SCAN  | walking primary OAM, copying hits into wbuf
  // FETCH | reading pattern bytes for each found slot
  // DONE  | one cycle; wbuf complete, done pulses on the way back to IDLE
  typedef logic [1:0] sp_eval_state_t;
  localparam sp_eval_state_t ST_IDLE  = 2'd0;
  localparam sp_eval_state_t ST_SCAN  = 2'd1;
  localparam sp_eval_state_t ST_FETCH = 2'd2;
  localparam sp_eval_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/sp_eval_pat_addr.sv
// Combinational pattern-table address for one sprite row.
//   tile_i    : tile index from OAM byte 1
//   fine_y_i  : row - Y (0..15) for this sprite
//   vflip_i   : attribute[7]
//   size16_i  : 1 = 8x16 sprites
//   pt_sel_i  : pattern table for 8x8 sprites
//   plane_i   : 0 = low bitplane, 1 = high bitplane
//   addr_o    : 14-bit VRAM address
module sp_pat_addr
  import sp_eval_pkg::*;
(
  input  logic [7:0]  tile_i,
  input  logic [3:0]  fine_y_i,
  input  logic        vflip_i,
  input  logic        size16_i,
  input  logic        pt_sel_i,
  input  logic        plane_i,
  output logic [13:0] addr_o
);

  logic [3:0] fy;

  always_comb begin
    fy = fine_y_i;
    if (vflip_i) fy = (size16_i ? 4'd15 : 4'd7) - fine_y_i;
    // 8x16: table comes from tile[0], fy[3] picks the top/bottom tile
    if (size16_i) addr_o = {1'b0, tile_i[0], tile_i[7:1], fy[3], plane_i, fy[2:0]};
    else          addr_o = {1'b0, pt_sel_i, tile_i, plane_i, fy[2:0]};
  end

endmodule

// File: rtl/sp_eval.sv
// Sprite evaluation and pattern fetch. Scans primary OAM for sprites on
// the requested row, keeps the first eight in a working buffer, fetches
// their pattern bytes, and commits the buffer to sec_oam on line_start.
//   clk, rst              : clock, async active-high reset
//   start, row, sp_size,
//   sp_pt_sel             : begin evaluation (parameters sampled on start)
//   line_start            : commit completed buffer / abort a running eval
//   oam_addr, oam_data    : primary OAM read port (1-cycle latency)
//   vram_addr, vram_re,
//   vram_data             : pattern read port (data the cycle after re)
//   sec_oam               : committed slots for the renderer
//   busy, done            : evaluation status
//   sp_overflow,
//   sp0_on_line           : committed flags
module sp_eval
  import sp_eval_pkg::*;
#(
  parameter int SP_SLOTS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [8:0]        row,
  input  logic              sp_size,
  input  logic              sp_pt_sel,
  input  logic              line_start,
  output logic [7:0]        oam_addr,
  input  logic [7:0]        oam_data,
  output logic [13:0]       vram_addr,
  output logic              vram_re,
  input  logic [7:0]        vram_data,
  output second_oam_t [7:0] sec_oam,
  output logic              busy,
  output logic              done,
  output logic              sp_overflow,
  output logic              sp0_on_line
);

  localparam logic [5:0] LAST_ENTRY = 6'(OAM_ENTRIES - 1);

  sp_eval_state_t    state_q, state_d;
  logic [8:0]        row_q, row_d;
  logic              size_q, size_d;
  logic              pt_q, pt_d;
  logic [5:0]        n_q, n_d;
  logic [1:0]        bsel_q, bsel_d;
  logic              ph_q, ph_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        slot_q, slot_d;
  logic [1:0]        fph_q, fph_d;
  logic              hi_pend_q, hi_pend_d;
  second_oam_t [7:0] wbuf_q, wbuf_d;
  logic [7:0][3:0]   fy_q, fy_d;
  logic [7:0][7:0]   tile_q, tile_d;
  logic              ovf_q, ovf_d;
  logic              sp0_q, sp0_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              re_q, re_d;
  logic [13:0]       vaddr_q, vaddr_d;
  second_oam_t [7:0] sec_q, sec_d;
  logic              ovl_q, ovl_d;
  logic              sp0l_q, sp0l_d;

  logic [8:0]  diff;
  logic [4:0]  height;
  logic        hit;
  logic        next_entry;
  logic [3:0]  fslot;
  logic [2:0]  psel;
  logic [13:0] pat_addr;

  assign height = size_q ? SPRITE_HEIGHT_16 : SPRITE_HEIGHT_8;
  assign diff   = row_q - {1'b0, oam_data};
  assign hit    = diff < {4'd0, height};

  // At phase 0 a pending high byte closes out slot_q, so the next low
  // fetch belongs to the following slot.
  assign fslot = hi_pend_q ? slot_q + 4'd1 : slot_q;
  assign psel  = (fph_q == 2'd0) ? fslot[2:0] : slot_q[2:0];

  sp_pat_addr u_pat_addr (
    .tile_i   (tile_q[psel]),
    .fine_y_i (fy_q[psel]),
    .vflip_i  (wbuf_q[psel].attribute[7]),
    .size16_i (size_q),
    .pt_sel_i (pt_q),
    .plane_i  (fph_q[1]),
    .addr_o   (pat_addr)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    size_d     = size_q;
    pt_d       = pt_q;
    n_d        = n_q;
    bsel_d     = bsel_q;
    ph_d       = ph_q;
    cnt_d      = cnt_q;
    slot_d     = slot_q;
    fph_d      = fph_q;
    hi_pend_d  = hi_pend_q;
    wbuf_d     = wbuf_q;
    fy_d       = fy_q;
    tile_d     = tile_q;
    ovf_d      = ovf_q;
    sp0_d      = sp0_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    re_d       = re_q;
    vaddr_d    = vaddr_q;
    sec_d      = sec_q;
    ovl_d      = ovl_q;
    sp0l_d     = sp0l_q;
    next_entry = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          row_d   = row;
          size_d  = sp_size;
          pt_d    = sp_pt_sel;
          wbuf_d  = '0;
          fy_d    = '0;
          tile_d  = '0;
          cnt_d   = 4'd0;
          n_d     = 6'd0;
          bsel_d  = 2'd0;
          ph_d    = 1'b0;
          ovf_d   = 1'b0;
          sp0_d   = 1'b0;
          valid_d = 1'b0;
        end
      end
      ST_SCAN: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          case (bsel_q)
            2'd0: begin
              if (hit && cnt_q < 4'(SP_SLOTS)) begin
                bsel_d             = 2'd1;
                fy_d[cnt_q[2:0]]   = diff[3:0];
                if (n_q == 6'd0) sp0_d = 1'b1;
              end else begin
                if (hit) ovf_d = 1'b1;
                next_entry = 1'b1;
              end
            end
            2'd1: begin
              tile_d[cnt_q[2:0]] = oam_data;
              bsel_d             = 2'd2;
            end
            2'd2: begin
              wbuf_d[cnt_q[2:0]].attribute = oam_data;
              bsel_d                       = 2'd3;
            end
            default: begin
              wbuf_d[cnt_q[2:0]].x_pos  = oam_data;
              wbuf_d[cnt_q[2:0]].active = 1'b1;
              cnt_d                     = cnt_q + 4'd1;
              bsel_d                    = 2'd0;
              next_entry                = 1'b1;
            end
          endcase
          if (next_entry) begin
            if (n_q == LAST_ENTRY) begin
              state_d   = ST_FETCH;
              slot_d    = 4'd0;
              fph_d     = 2'd0;
              hi_pend_d = 1'b0;
            end else begin
              n_d = n_q + 6'd1;
            end
          end
        end
      end
      ST_FETCH: begin
        case (fph_q)
          2'd0: begin
            if (hi_pend_q) wbuf_d[slot_q[2:0]].bitmap_hi = vram_data;
            hi_pend_d = 1'b0;
            slot_d    = fslot;
            if (fslot == cnt_q) begin
              state_d = ST_DONE;
            end else begin
              vaddr_d = pat_addr;
              re_d    = 1'b1;
              fph_d   = 2'd1;
            end
          end
          2'd1: begin
            re_d  = 1'b0;
            fph_d = 2'd2;
          end
          2'd2: begin
            wbuf_d[slot_q[2:0]].bitmap_lo = vram_data;
            vaddr_d = pat_addr;
            re_d    = 1'b1;
            fph_d   = 2'd3;
          end
          default: begin
            re_d      = 1'b0;
            fph_d     = 2'd0;
            hi_pend_d = 1'b1;
          end
        endcase
      end
      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        valid_d = 1'b1;
      end
    endcase

    // Commit reads the _q copies, so a simultaneous start still commits
    // the previous line.
    if (line_start) begin
      if (state_q == ST_SCAN || state_q == ST_FETCH) begin
        state_d = ST_IDLE;
        re_d    = 1'b0;
        valid_d = 1'b0;
        sec_d   = '0;
        ovl_d   = 1'b0;
        sp0l_d  = 1'b0;
      end else if (state_q == ST_DONE || valid_q) begin
        sec_d  = wbuf_q;
        ovl_d  = ovf_q;
        sp0l_d = sp0_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      size_q    <= 1'b0;
      pt_q      <= 1'b0;
      n_q       <= '0;
      bsel_q    <= '0;
      ph_q      <= 1'b0;
      cnt_q     <= '0;
      slot_q    <= '0;
      fph_q     <= '0;
      hi_pend_q <= 1'b0;
      wbuf_q    <= '0;
      fy_q      <= '0;
      tile_q    <= '0;
      ovf_q     <= 1'b0;
      sp0_q     <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      re_q      <= 1'b0;
      vaddr_q   <= '0;
      sec_q     <= '0;
      ovl_q     <= 1'b0;
      sp0l_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      size_q    <= size_d;
      pt_q      <= pt_d;
      n_q       <= n_d;
      bsel_q    <= bsel_d;
      ph_q      <= ph_d;
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      fph_q     <= fph_d;
      hi_pend_q <= hi_pend_d;
      wbuf_q    <= wbuf_d;
      fy_q      <= fy_d;
      tile_q    <= tile_d;
      ovf_q     <= ovf_d;
      sp0_q     <= sp0_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      re_q      <= re_d;
      vaddr_q   <= vaddr_d;
      sec_q     <= sec_d;
      ovl_q     <= ovl_d;
      sp0l_q    <= sp0l_d;
    end
  end

  assign oam_addr    = {n_q, bsel_q};
  assign vram_addr   = vaddr_q;
  assign vram_re     = re_q;
  assign sec_oam     = sec_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign sp_overflow = ovl_q;
  assign sp0_on_line = sp0l_q;

endmodule

// File: tb/tb_sp_eval.sv
module tb_sp_eval;
  import sp_eval_pkg::*;

  logic              clk = 1'b0;
  logic              rst, start, line_start, sp_size, sp_pt_sel;
  logic [8:0]        row;
  logic [7:0]        oam_addr, oam_data, vram_data;
  logic [13:0]       vram_addr;
  logic              vram_re, busy, done, sp_overflow, sp0_on_line;
  second_oam_t [7:0] sec_oam;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  logic [7:0]  oam [0:255];
  logic [13:0] vq[$];
  second_oam_t exp_s;

  sp_eval #(.SP_SLOTS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .row(row), .sp_size(sp_size),
    .sp_pt_sel(sp_pt_sel), .line_start(line_start), .oam_addr(oam_addr),
    .oam_data(oam_data), .vram_addr(vram_addr), .vram_re(vram_re),
    .vram_data(vram_data), .sec_oam(sec_oam), .busy(busy), .done(done),
    .sp_overflow(sp_overflow), .sp0_on_line(sp0_on_line)
  );

  always #5 clk = ~clk;

  always @(posedge clk) oam_data <= oam[oam_addr];

  always @(posedge clk) begin
    if (vram_re) begin
      vram_data <= vram_addr[7:0] ^ 8'hA5;
      vq.push_back(vram_addr);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_oam;
    for (int i = 0; i < 256; i++) oam[i] = (i % 4 == 0) ? 8'hF0 : 8'h00;
  endtask

  task automatic pulse_ls;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic run_eval(input logic [8:0] r, input logic sz, input logic pt,
                          input int restart_at, output int cyc);
    row = r; sp_size = sz; sp_pt_sel = pt; start = 1'b1;
    vq.delete();
    tick();
    start = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      start = (i == restart_at);
      if (i == restart_at) row = 9'd0;
      if (done) begin
        cyc = i;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (sp_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", sp_overflow); end
    n_cmp++; if (sp0_on_line !== 1'b0) begin n_fail++; $display("FAIL reset_sp0: got %b want 0", sp0_on_line); end
    n_cmp++; if (vram_re !== 1'b0) begin n_fail++; $display("FAIL reset_re: got %b want 0", vram_re); end
    n_cmp++; if (oam_addr !== 8'h00) begin n_fail++; $display("FAIL reset_oam_addr: got %h want 00", oam_addr); end
    n_cmp++; if (vram_addr !== 14'h0) begin n_fail++; $display("FAIL reset_vram_addr: got %h want 0", vram_addr); end
    n_cmp++; if (sec_oam !== '0) begin n_fail++; $display("FAIL reset_sec_oam: got %h want 0", sec_oam); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_no_sprite;
    int c;
    clear_oam();
    run_eval(9'd50, 1'b0, 1'b0, 0, c);
    n_cmp++; if (c !== 130) begin n_fail++; $display("FAIL nospr_cycles: got %0d want 130", c); end
    n_cmp++; if (vq.size() !== 0) begin n_fail++; $display("FAIL nospr_vram_reads: got %0d want 0", vq.size()); end
    tick();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL nospr_done_pulse: got done=%b busy=%b want 0 0", done, busy); end
    pulse_ls();
    n_cmp++; if (sec_oam !== '0) begin n_fail++; $display("FAIL nospr_sec_oam: got %h want 0", sec_oam); end
    n_cmp++; if (sp_overflow !== 1'b0) begin n_fail++; $display("FAIL nospr_ovf: got %b want 0", sp_overflow); end
  endtask

  task automatic test_single;
    int c;
    clear_oam();
    oam[0] = 8'd10; oam[1] = 8'h21; oam[2] = 8'h01; oam[3] = 8'd40;
    run_eval(9'd13, 1'b0, 1'b1, 0, c);
    n_cmp++; if (c !== 140) begin n_fail++; $display("FAIL single_cycles: got %0d want 140", c); end
    n_cmp++; if (vq.size() !== 2) begin n_fail++; $display("FAIL single_nreads: got %0d want 2", vq.size()); end
    else begin
      n_cmp++; if (vq[0] !== 14'h1213 || vq[1] !== 14'h121B) begin n_fail++; $display("FAIL single_addrs: got %h %h want 1213 121b", vq[0], vq[1]); end
    end
    n_cmp++; if (sec_oam[0].active !== 1'b0) begin n_fail++; $display("FAIL single_precommit: got active=%b want 0", sec_oam[0].active); end
    pulse_ls();
    exp_s = '{1'b1, 8'd40, 8'h01, 8'hB6, 8'hBE};
    n_cmp++; if (sec_oam[0] !== exp_s) begin n_fail++; $display("FAIL single_slot0: got %h want %h", sec_oam[0], exp_s); end
    n_cmp++; if (sec_oam[1] !== '0) begin n_fail++; $display("FAIL single_slot1: got %h want 0", sec_oam[1]); end
    n_cmp++; if (sp0_on_line !== 1'b1) begin n_fail++; $display("FAIL single_sp0: got %b want 1", sp0_on_line); end
  endtask

  task automatic test_vflip;
    int c;
    clear_oam();
    oam[0] = 8'd10; oam[1] = 8'h21; oam[2] = 8'h81; oam[3] = 8'd40;
    run_eval(9'd13, 1'b0, 1'b1, 0, c);
    n_cmp++; if (vq.size() !== 2) begin n_fail++; $display("FAIL vflip_nreads: got %0d want 2", vq.size()); end
    else begin
      n_cmp++; if (vq[0] !== 14'h1214 || vq[1] !== 14'h121C) begin n_fail++; $display("FAIL vflip_addrs: got %h %h want 1214 121c", vq[0], vq[1]); end
    end
    pulse_ls();
    exp_s = '{1'b1, 8'd40, 8'h81, 8'hB1, 8'hB9};
    n_cmp++; if (sec_oam[0] !== exp_s) begin n_fail++; $display("FAIL vflip_slot0: got %h want %h", sec_oam[0], exp_s); end
  endtask

  task automatic test_8x16;
    int c;
    clear_oam();
    oam[12] = 8'd0; oam[13] = 8'h35; oam[14] = 8'h02; oam[15] = 8'h77;
    run_eval(9'd9, 1'b1, 1'b0, 0, c);
    n_cmp++; if (vq.size() !== 2) begin n_fail++; $display("FAIL tall_nreads: got %0d want 2", vq.size()); end
    else begin
      n_cmp++; if (vq[0] !== 14'h1351 || vq[1] !== 14'h1359) begin n_fail++; $display("FAIL tall_addrs: got %h %h want 1351 1359", vq[0], vq[1]); end
    end
    pulse_ls();
    exp_s = '{1'b1, 8'h77, 8'h02, 8'hF4, 8'hFC};
    n_cmp++; if (sec_oam[0] !== exp_s) begin n_fail++; $display("FAIL tall_slot0: got %h want %h", sec_oam[0], exp_s); end
    n_cmp++; if (sp0_on_line !== 1'b0) begin n_fail++; $display("FAIL tall_sp0: got %b want 0", sp0_on_line); end
  endtask

  task automatic test_overflow;
    int c;
    clear_oam();
    for (int i = 0; i < 10; i++) begin
      oam[4*i] = 8'd20; oam[4*i+1] = 8'h10 + 8'(i); oam[4*i+2] = 8'h00; oam[4*i+3] = 8'(8*i);
    end
    // second start mid-scan must be ignored
    run_eval(9'd22, 1'b0, 1'b0, 50, c);
    n_cmp++; if (c !== 210) begin n_fail++; $display("FAIL ovf_cycles: got %0d want 210", c); end
    pulse_ls();
    for (int s = 0; s < 8; s++) begin
      n_cmp++;
      if (sec_oam[s].active !== 1'b1 || sec_oam[s].x_pos !== 8'(8*s)) begin
        n_fail++; $display("FAIL ovf_slot%0d: got active=%b x=%0d want 1 %0d", s, sec_oam[s].active, sec_oam[s].x_pos, 8*s);
      end
    end
    exp_s = '{1'b1, 8'd0, 8'h00, 8'hA7, 8'hAF};
    n_cmp++; if (sec_oam[0] !== exp_s) begin n_fail++; $display("FAIL ovf_slot0_full: got %h want %h", sec_oam[0], exp_s); end
    exp_s = '{1'b1, 8'd56, 8'h00, 8'hD7, 8'hDF};
    n_cmp++; if (sec_oam[7] !== exp_s) begin n_fail++; $display("FAIL ovf_slot7_full: got %h want %h", sec_oam[7], exp_s); end
    n_cmp++; if (sp_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", sp_overflow); end
    n_cmp++; if (sp0_on_line !== 1'b1) begin n_fail++; $display("FAIL ovf_sp0: got %b want 1", sp0_on_line); end
  endtask

  task automatic test_abort;
    int d0;
    row = 9'd22; sp_size = 1'b0; sp_pt_sel = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b want 1", busy); end
    d0 = done_cnt;
    pulse_ls();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%b want 0", busy); end
    n_cmp++; if (sec_oam !== '0) begin n_fail++; $display("FAIL abort_sec_oam: got %h want 0", sec_oam); end
    n_cmp++; if (sp_overflow !== 1'b0 || sp0_on_line !== 1'b0) begin n_fail++; $display("FAIL abort_flags: got %b %b want 0 0", sp_overflow, sp0_on_line); end
    repeat (250) tick();
    n_cmp++; if (done_cnt !== d0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0); end
    pulse_ls();
    n_cmp++; if (sec_oam !== '0) begin n_fail++; $display("FAIL abort_no_commit: got %h want 0", sec_oam); end
  endtask

  task automatic test_back_to_back;
    int c;
    clear_oam();
    oam[0] = 8'd10; oam[1] = 8'h21; oam[2] = 8'h01; oam[3] = 8'd40;
    run_eval(9'd13, 1'b0, 1'b1, 0, c);
    oam[3] = 8'h63;
    start = 1'b1; line_start = 1'b1;
    tick();
    start = 1'b0; line_start = 1'b0;
    n_cmp++; if (sec_oam[0].x_pos !== 8'd40 || sec_oam[0].active !== 1'b1) begin n_fail++; $display("FAIL b2b_old_commit: got x=%h active=%b want 28 1", sec_oam[0].x_pos, sec_oam[0].active); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_started: got busy=%b want 1", busy); end
    c = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (done) begin c = i; break; end
    end
    n_cmp++; if (c !== 140) begin n_fail++; $display("FAIL b2b_cycles: got %0d want 140", c); end
    pulse_ls();
    n_cmp++; if (sec_oam[0].x_pos !== 8'h63) begin n_fail++; $display("FAIL b2b_new_commit: got x=%h want 63", sec_oam[0].x_pos); end
  endtask

  task automatic test_rst_mid_fetch;
    bit seen;
    row = 9'd13; sp_size = 1'b0; sp_pt_sel = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (vram_re) begin seen = 1'b1; break; end
      tick();
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL rst_fetch_reached: got no vram_re want vram_re"); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || vram_re !== 1'b0) begin n_fail++; $display("FAIL rst_async_ctl: got busy=%b done=%b re=%b want 0 0 0", busy, done, vram_re); end
    n_cmp++; if (oam_addr !== 8'h00 || vram_addr !== 14'h0) begin n_fail++; $display("FAIL rst_async_addr: got %h %h want 00 0000", oam_addr, vram_addr); end
    n_cmp++; if (sec_oam !== '0 || sp_overflow !== 1'b0 || sp0_on_line !== 1'b0) begin n_fail++; $display("FAIL rst_async_sec: got %h %b %b want 0 0 0", sec_oam, sp_overflow, sp0_on_line); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; line_start = 1'b0; sp_size = 1'b0; sp_pt_sel = 1'b0;
    row = 9'd0; vram_data = 8'h00;
    clear_oam();
    test_reset();
    test_no_sprite();
    test_single();
    test_vflip();
    test_8x16();
    test_overflow();
    test_abort();
    test_back_to_back();
    test_rst_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
